// File: rtl/ccip_mem_responder.sv
// CCI-P memory responder: queues single-line read/write requests, ages them against
// a free-running timestamp, and answers from a local line store.
module ccip_mem_responder #(
    parameter int MEM_LINES      = 256,
    parameter int RD_LATENCY     = 8,
    parameter int WR_LATENCY     = 4,
    parameter int QUEUE_DEPTH    = 16,
    parameter int ALMFULL_THRESH = 12
) (
    input  logic         Clk,
    input  logic         Resetb,
    input  logic         c0_req_valid,
    input  logic [41:0]  c0_req_addr,
    input  logic [15:0]  c0_req_mdata,
    input  logic [1:0]   c0_req_cl_len,
    input  logic         c1_req_valid,
    input  logic [41:0]  c1_req_addr,
    input  logic [15:0]  c1_req_mdata,
    input  logic [1:0]   c1_req_cl_len,
    input  logic [511:0] c1_req_data,
    output logic         c0TxAlmFull,
    output logic         c1TxAlmFull,
    output logic         c0_rsp_valid,
    output logic [15:0]  c0_rsp_mdata,
    output logic [511:0] c0_rsp_data,
    output logic         c1_rsp_valid,
    output logic [15:0]  c1_rsp_mdata,
    output logic         c1_rsp_format,
    output logic [1:0]   c1_rsp_cl_num,
    output logic         err_unsupported,
    output logic         err_overflow
);
    localparam int IW = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
    localparam int QW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [QW:0] Q_FULL = (QW + 1)'(QUEUE_DEPTH);
    localparam logic [QW:0] Q_ALM  = (QW + 1)'(ALMFULL_THRESH);
    localparam logic [15:0] RD_LAT = 16'(RD_LATENCY);
    localparam logic [15:0] WR_LAT = 16'(WR_LATENCY);

    logic [15:0]  ts;
    logic [511:0] mem [MEM_LINES];

    logic [IW-1:0] rq_idx   [QUEUE_DEPTH];
    logic [15:0]   rq_mdata [QUEUE_DEPTH];
    logic [15:0]   rq_stamp [QUEUE_DEPTH];
    logic [QW-1:0] rq_head, rq_tail;
    logic [QW:0]   rq_cnt;

    logic [IW-1:0] wq_idx   [QUEUE_DEPTH];
    logic [15:0]   wq_mdata [QUEUE_DEPTH];
    logic [15:0]   wq_stamp [QUEUE_DEPTH];
    logic [511:0]  wq_data  [QUEUE_DEPTH];
    logic [QW-1:0] wq_head, wq_tail;
    logic [QW:0]   wq_cnt;

    logic        rd_len_ok, wr_len_ok, rd_push, wr_push, rd_pop, wr_pop;
    logic        rd_ovf, wr_ovf;
    logic [15:0] rd_age, wr_age;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{c0_req_addr[41:IW], c1_req_addr[41:IW]};
    assign c1_rsp_format    = 1'b0;
    assign c1_rsp_cl_num    = 2'b00;

    // Age is modulo 2^16, so the comparison stays correct across timestamp wrap.
    always_comb begin
        rd_len_ok = c0_req_cl_len == 2'b00;
        wr_len_ok = c1_req_cl_len == 2'b00;
        rd_push   = c0_req_valid && rd_len_ok && (rq_cnt != Q_FULL);
        wr_push   = c1_req_valid && wr_len_ok && (wq_cnt != Q_FULL);
        rd_ovf    = c0_req_valid && rd_len_ok && (rq_cnt == Q_FULL);
        wr_ovf    = c1_req_valid && wr_len_ok && (wq_cnt == Q_FULL);
        rd_age    = ts - rq_stamp[rq_head];
        wr_age    = ts - wq_stamp[wq_head];
        rd_pop    = (rq_cnt != '0) && (rd_age >= RD_LAT);
        wr_pop    = (wq_cnt != '0) && (wr_age >= WR_LAT);
    end

    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            ts              <= '0;
            rq_head         <= '0;
            rq_tail         <= '0;
            rq_cnt          <= '0;
            wq_head         <= '0;
            wq_tail         <= '0;
            wq_cnt          <= '0;
            c0_rsp_valid    <= 1'b0;
            c1_rsp_valid    <= 1'b0;
            c0TxAlmFull     <= 1'b0;
            c1TxAlmFull     <= 1'b0;
            err_unsupported <= 1'b0;
            err_overflow    <= 1'b0;
        end else begin
            ts           <= ts + 16'd1;
            rq_cnt       <= rq_cnt + {{QW{1'b0}}, rd_push} - {{QW{1'b0}}, rd_pop};
            wq_cnt       <= wq_cnt + {{QW{1'b0}}, wr_push} - {{QW{1'b0}}, wr_pop};
            c0_rsp_valid <= rd_pop;
            c1_rsp_valid <= wr_pop;
            c0TxAlmFull  <= rq_cnt >= Q_ALM;
            c1TxAlmFull  <= wq_cnt >= Q_ALM;
            if (rd_push) rq_tail <= rq_tail + QW'(1);
            if (wr_push) wq_tail <= wq_tail + QW'(1);
            if (rd_pop)  rq_head <= rq_head + QW'(1);
            if (wr_pop)  wq_head <= wq_head + QW'(1);
            if ((c0_req_valid && !rd_len_ok) || (c1_req_valid && !wr_len_ok))
                err_unsupported <= 1'b1;
            if (rd_ovf || wr_ovf)
                err_overflow <= 1'b1;
        end
    end

    // Storage and response payload are unreset; a same-edge commit cannot disturb the read sample.
    always_ff @(posedge Clk) begin
        if (rd_push) begin
            rq_idx[rq_tail]   <= c0_req_addr[IW-1:0];
            rq_mdata[rq_tail] <= c0_req_mdata;
            rq_stamp[rq_tail] <= ts;
        end
        if (wr_push) begin
            wq_idx[wq_tail]   <= c1_req_addr[IW-1:0];
            wq_mdata[wq_tail] <= c1_req_mdata;
            wq_stamp[wq_tail] <= ts;
            wq_data[wq_tail]  <= c1_req_data;
        end
        if (rd_pop) begin
            c0_rsp_mdata <= rq_mdata[rq_head];
            c0_rsp_data  <= mem[rq_idx[rq_head]];
        end
        if (wr_pop) begin
            mem[wq_idx[wq_head]] <= wq_data[wq_head];
            c1_rsp_mdata         <= wq_mdata[wq_head];
        end
    end
endmodule

// File: tb/tb_ccip_mem_responder.sv
// Bench for ccip_mem_responder: default instance plus a long-read-latency instance
// used to fill the read queue.
module tb_ccip_mem_responder;
    logic         Clk = 1'b0;
    logic         Resetb = 1'b0;

    logic         c0_req_valid, c1_req_valid;
    logic [41:0]  c0_req_addr, c1_req_addr;
    logic [15:0]  c0_req_mdata, c1_req_mdata;
    logic [1:0]   c0_req_cl_len, c1_req_cl_len;
    logic [511:0] c1_req_data;
    logic         c0TxAlmFull, c1TxAlmFull, c0_rsp_valid, c1_rsp_valid;
    logic [15:0]  c0_rsp_mdata, c1_rsp_mdata;
    logic [511:0] c0_rsp_data;
    logic         c1_rsp_format, err_unsupported, err_overflow;
    logic [1:0]   c1_rsp_cl_num;

    logic         b_c0_req_valid, b_c1_req_valid;
    logic [41:0]  b_c0_req_addr, b_c1_req_addr;
    logic [15:0]  b_c0_req_mdata, b_c1_req_mdata;
    logic [1:0]   b_c0_req_cl_len, b_c1_req_cl_len;
    logic [511:0] b_c1_req_data;
    logic         b_c0TxAlmFull, b_c1TxAlmFull, b_c0_rsp_valid, b_c1_rsp_valid;
    logic [15:0]  b_c0_rsp_mdata, b_c1_rsp_mdata;
    logic [511:0] b_c0_rsp_data;
    logic         b_c1_rsp_format, b_err_unsupported, b_err_overflow;
    logic [1:0]   b_c1_rsp_cl_num;

    ccip_mem_responder dut (
        .Clk(Clk), .Resetb(Resetb),
        .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr),
        .c0_req_mdata(c0_req_mdata), .c0_req_cl_len(c0_req_cl_len),
        .c1_req_valid(c1_req_valid), .c1_req_addr(c1_req_addr),
        .c1_req_mdata(c1_req_mdata), .c1_req_cl_len(c1_req_cl_len),
        .c1_req_data(c1_req_data),
        .c0TxAlmFull(c0TxAlmFull), .c1TxAlmFull(c1TxAlmFull),
        .c0_rsp_valid(c0_rsp_valid), .c0_rsp_mdata(c0_rsp_mdata), .c0_rsp_data(c0_rsp_data),
        .c1_rsp_valid(c1_rsp_valid), .c1_rsp_mdata(c1_rsp_mdata),
        .c1_rsp_format(c1_rsp_format), .c1_rsp_cl_num(c1_rsp_cl_num),
        .err_unsupported(err_unsupported), .err_overflow(err_overflow)
    );

    ccip_mem_responder #(.RD_LATENCY(255)) dut_slow (
        .Clk(Clk), .Resetb(Resetb),
        .c0_req_valid(b_c0_req_valid), .c0_req_addr(b_c0_req_addr),
        .c0_req_mdata(b_c0_req_mdata), .c0_req_cl_len(b_c0_req_cl_len),
        .c1_req_valid(b_c1_req_valid), .c1_req_addr(b_c1_req_addr),
        .c1_req_mdata(b_c1_req_mdata), .c1_req_cl_len(b_c1_req_cl_len),
        .c1_req_data(b_c1_req_data),
        .c0TxAlmFull(b_c0TxAlmFull), .c1TxAlmFull(b_c1TxAlmFull),
        .c0_rsp_valid(b_c0_rsp_valid), .c0_rsp_mdata(b_c0_rsp_mdata), .c0_rsp_data(b_c0_rsp_data),
        .c1_rsp_valid(b_c1_rsp_valid), .c1_rsp_mdata(b_c1_rsp_mdata),
        .c1_rsp_format(b_c1_rsp_format), .c1_rsp_cl_num(b_c1_rsp_cl_num),
        .err_unsupported(b_err_unsupported), .err_overflow(b_err_overflow)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        wr;
        logic [41:0] addr;
        logic [15:0] mdata;
        logic [1:0]  cl_len;
        logic [7:0]  wdata;
        logic        exp_rsp;
        logic [7:0]  exp_rdata;
        logic        exp_unsup;
    } vec_t;

    typedef struct {
        logic [15:0]  mdata;
        logic [511:0] data;
        int           due;
        logic         chk_data;
    } exp_t;

    exp_t c0_exp[$];
    exp_t c1_exp[$];
    exp_t b0_exp[$];
    exp_t e0, e1, e2;
    vec_t vecs[10];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every response must match the oldest expectation on its channel, on its due cycle.
    always @(negedge Clk) begin
        if (c0_rsp_valid === 1'b1) begin
            if (c0_exp.size() == 0) begin
                checks++; errors++;
                $display("FAIL c0_unexpected: got response mdata %0h at cycle %0d, expected none", c0_rsp_mdata, cyc);
            end else begin
                e0 = c0_exp.pop_front();
                chk("c0_mdata", 512'(c0_rsp_mdata), 512'(e0.mdata));
                if (e0.chk_data) chk("c0_data", c0_rsp_data, e0.data);
                chk("c0_latency", 512'(cyc), 512'(e0.due));
            end
        end
        if (c1_rsp_valid === 1'b1) begin
            if (c1_exp.size() == 0) begin
                checks++; errors++;
                $display("FAIL c1_unexpected: got response mdata %0h at cycle %0d, expected none", c1_rsp_mdata, cyc);
            end else begin
                e1 = c1_exp.pop_front();
                chk("c1_mdata", 512'(c1_rsp_mdata), 512'(e1.mdata));
                chk("c1_format_clnum", 512'({c1_rsp_format, c1_rsp_cl_num}), 512'(3'b000));
                chk("c1_latency", 512'(cyc), 512'(e1.due));
            end
        end
        if (b_c0_rsp_valid === 1'b1) begin
            if (b0_exp.size() == 0) begin
                checks++; errors++;
                $display("FAIL slow_c0_unexpected: got response mdata %0h at cycle %0d, expected none", b_c0_rsp_mdata, cyc);
            end else begin
                e2 = b0_exp.pop_front();
                chk("slow_c0_mdata", 512'(b_c0_rsp_mdata), 512'(e2.mdata));
                chk("slow_c0_latency", 512'(cyc), 512'(e2.due));
            end
        end
    end

    task automatic idle_in();
        c0_req_valid = 1'b0; c1_req_valid = 1'b0;
        b_c0_req_valid = 1'b0; b_c1_req_valid = 1'b0;
    endtask

    task automatic rd(input logic [41:0] a, input logic [15:0] md, input logic [1:0] len,
                      input logic exp_rsp, input logic [7:0] d);
        c0_req_valid = 1'b1; c0_req_addr = a; c0_req_mdata = md; c0_req_cl_len = len;
        if (exp_rsp) c0_exp.push_back('{mdata: md, data: {64{d}}, due: cyc + 9, chk_data: 1'b1});
    endtask

    task automatic wr(input logic [41:0] a, input logic [15:0] md, input logic [1:0] len,
                      input logic exp_rsp, input logic [7:0] d);
        c1_req_valid = 1'b1; c1_req_addr = a; c1_req_mdata = md; c1_req_cl_len = len;
        c1_req_data = {64{d}};
        if (exp_rsp) c1_exp.push_back('{mdata: md, data: '0, due: cyc + 5, chk_data: 1'b0});
    endtask

    task automatic rd_slow(input logic [15:0] md, input logic exp_rsp);
        b_c0_req_valid = 1'b1; b_c0_req_addr = 42'(md[3:0]); b_c0_req_mdata = md; b_c0_req_cl_len = 2'b00;
        if (exp_rsp) b0_exp.push_back('{mdata: md, data: '0, due: cyc + 256, chk_data: 1'b0});
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (c0_exp.size() + c1_exp.size() + b0_exp.size()) != 0; i++)
            @(negedge Clk);
        if ((c0_exp.size() + c1_exp.size() + b0_exp.size()) != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d/%0d/%0d outstanding expected 0/0/0",
                     c0_exp.size(), c1_exp.size(), b0_exp.size());
            c0_exp.delete(); c1_exp.delete(); b0_exp.delete();
        end
        repeat (5) @(negedge Clk);
    endtask

    initial begin
        int c, due0, rel;
        vecs[0] = '{1'b1, 42'h005,         16'h0011, 2'd0, 8'hA5, 1'b1, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 42'h005,         16'h0022, 2'd0, 8'h00, 1'b1, 8'hA5, 1'b0};
        vecs[2] = '{1'b1, 42'h105,         16'h0033, 2'd0, 8'h3C, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{1'b0, 42'h005,         16'h0044, 2'd0, 8'h00, 1'b1, 8'h3C, 1'b0};
        vecs[4] = '{1'b1, 42'h200000000FF, 16'hFFFF, 2'd0, 8'h5A, 1'b1, 8'h00, 1'b0};
        vecs[5] = '{1'b0, 42'h0FF,         16'h0000, 2'd0, 8'h00, 1'b1, 8'h5A, 1'b0};
        vecs[6] = '{1'b0, 42'h007,         16'h0055, 2'd2, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[7] = '{1'b1, 42'h009,         16'h0066, 2'd1, 8'h77, 1'b0, 8'h00, 1'b1};
        vecs[8] = '{1'b1, 42'h003,         16'h0077, 2'd0, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[9] = '{1'b0, 42'h003,         16'h0088, 2'd0, 8'h00, 1'b1, 8'h00, 1'b1};

        idle_in();
        c0_req_addr = '0; c0_req_mdata = '0; c0_req_cl_len = '0;
        c1_req_addr = '0; c1_req_mdata = '0; c1_req_cl_len = '0; c1_req_data = '0;
        b_c0_req_addr = '0; b_c0_req_mdata = '0; b_c0_req_cl_len = '0;
        b_c1_req_addr = '0; b_c1_req_mdata = '0; b_c1_req_cl_len = '0; b_c1_req_data = '0;

        repeat (3) @(negedge Clk);
        chk("reset_rsp_valid", 512'({c0_rsp_valid, c1_rsp_valid, b_c0_rsp_valid, b_c1_rsp_valid}), 512'(0));
        chk("reset_almfull", 512'({c0TxAlmFull, c1TxAlmFull, b_c0TxAlmFull, b_c1TxAlmFull}), 512'(0));
        chk("reset_errors", 512'({err_unsupported, err_overflow, b_err_unsupported, b_err_overflow}), 512'(0));
        Resetb = 1'b1;
        @(negedge Clk);

        // Table of single transactions on the default instance.
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr)
                wr(vecs[i].addr, vecs[i].mdata, vecs[i].cl_len, vecs[i].exp_rsp, vecs[i].wdata);
            else
                rd(vecs[i].addr, vecs[i].mdata, vecs[i].cl_len, vecs[i].exp_rsp, vecs[i].exp_rdata);
            @(negedge Clk);
            idle_in();
            drain(40);
            chk($sformatf("vec%0d_err_unsupported", i), 512'(err_unsupported), 512'(vecs[i].exp_unsup));
        end
        chk("table_err_overflow", 512'(err_overflow), 512'(0));

        // Read pop and write commit to line 3 land on the same edge.
        rd(42'h003, 16'h0101, 2'd0, 1'b1, 8'h00);
        @(negedge Clk); idle_in();
        repeat (3) @(negedge Clk);
        wr(42'h003, 16'h0102, 2'd0, 1'b1, 8'hFF);
        @(negedge Clk); idle_in();
        drain(40);
        rd(42'h003, 16'h0103, 2'd0, 1'b1, 8'hFF);
        @(negedge Clk); idle_in();
        drain(40);

        // Slow instance: 16 back-to-back reads, almost-full timing, ordered responses.
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("slow_almfull_k%0d", k), 512'(b_c0TxAlmFull), 512'(k >= 13));
            rd_slow(16'(16'h0200 + k), 1'b1);
            @(negedge Clk);
        end
        idle_in();
        chk("slow_almfull_full", 512'(b_c0TxAlmFull), 512'(1));
        chk("slow_no_overflow", 512'(b_err_overflow), 512'(0));
        drain(400);
        chk("slow_almfull_drained", 512'(b_c0TxAlmFull), 512'(0));

        // Slow instance: 17th read overflows and is dropped.
        for (int k = 0; k < 17; k++) begin
            rd_slow(16'(16'h0300 + k), k < 16);
            @(negedge Clk);
        end
        idle_in();
        chk("slow_overflow_set", 512'(b_err_overflow), 512'(1));
        chk("slow_overflow_unsup", 512'(b_err_unsupported), 512'(0));
        drain(400);
        chk("slow_overflow_sticky", 512'(b_err_overflow), 512'(1));

        // Reset with reads in flight while a response is on the bus.
        c = cyc;
        for (int k = 0; k < 4; k++) begin
            rd(42'h0FF, 16'(16'h0400 + k), 2'd0, 1'b1, 8'h5A);
            @(negedge Clk);
        end
        idle_in();
        due0 = c + 9;
        for (int i = 0; i < 20 && cyc < due0; i++) @(negedge Clk);
        #2;
        chk("pre_reset_rsp_valid", 512'(c0_rsp_valid), 512'(1));
        Resetb = 1'b0;
        #1;
        chk("async_reset_rsp_valid", 512'(c0_rsp_valid), 512'(0));
        chk("async_reset_errors", 512'({err_unsupported, err_overflow, b_err_overflow}), 512'(0));
        c0_exp.delete();
        @(negedge Clk);
        Resetb = 1'b1;
        rel = cyc;
        repeat (30) @(negedge Clk);
        chk("post_reset_errors", 512'({err_unsupported, err_overflow}), 512'(0));
        chk("post_reset_almfull", 512'({c0TxAlmFull, c1TxAlmFull}), 512'(0));

        // Reads straddling the timestamp wrap; line 0xFF survives reset.
        for (int i = 0; i < 70000 && cyc < rel + 65532; i++) @(negedge Clk);
        for (int k = 0; k < 8; k++) begin
            rd(42'h0FF, 16'(16'h0500 + k), 2'd0, 1'b1, 8'h5A);
            @(negedge Clk);
        end
        idle_in();
        drain(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
